// File: rtl/dose_actuator.sv
// rtl/dose_actuator.sv - converts dispense requests into timed servo open/close cycles with dose tracking
//
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   asynchronous active-high reset
//   trigger       in   dispense request level; rising edge requests one dose
//   refill        in   refill level; rising edge loads doses_left from refill_count
//   refill_count  in   [3:0] dose count loaded on refill
//   servo_pwm     out  registered servo PWM, one full-width pulse per frame
//   busy          out  high while a dose cycle (open or close phase) is active
//   done          out  one-cycle pulse in the last cycle of a dose cycle
//   doses_left    out  [3:0] remaining doses in the compartment
//   empty         out  doses_left == 0
//   pending       out  [1:0] queued requests not yet started
//   overflow      out  sticky: request dropped because the queue was full
//   denied        out  sticky: request dropped because no dose was available
module dose_actuator #(
    parameter int PWM_PERIOD   = 1000000,
    parameter int PULSE_CLOSED = 50000,
    parameter int PULSE_OPEN   = 100000,
    parameter int OPEN_FRAMES  = 25,
    parameter int CLOSE_FRAMES = 25,
    parameter int QUEUE_MAX    = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       trigger,
    input  logic       refill,
    input  logic [3:0] refill_count,
    output logic       servo_pwm,
    output logic       busy,
    output logic       done,
    output logic [3:0] doses_left,
    output logic       empty,
    output logic [1:0] pending,
    output logic       overflow,
    output logic       denied
);

    localparam int CW   = $clog2(PWM_PERIOD);
    localparam int FMAX = (OPEN_FRAMES > CLOSE_FRAMES) ? OPEN_FRAMES : CLOSE_FRAMES;
    localparam int IW   = (FMAX > 1) ? $clog2(FMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_CLOSE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   frame_cnt, cnt_next;
    logic [CW-1:0]   width_reg, width_next;
    logic [IW-1:0]   frame_idx, idx_next;
    logic            trig_q, refill_q;
    logic [1:0]      pending_q, pend_next;
    logic [2:0]      pend_eff;
    logic [3:0]      doses_q, dose_base, dose_next;
    logic            overflow_q, denied_q, done_q, busy_q, pwm_q;
    logic            over_next, deny_next, done_next, launch;

    logic            trig_rise, refill_rise, frame_end, in_flight, complete;
    logic [3:0]      committed;
    logic            req_deny, req_over, req_acc;

    assign trig_rise   = trigger & ~trig_q;
    assign refill_rise = refill & ~refill_q;
    assign frame_end   = (frame_cnt == CW'(PWM_PERIOD - 1));
    assign in_flight   = (state != S_IDLE);

    // A request is only admitted if a dose remains for it after every
    // request already queued or running has taken its own.
    assign committed = {2'b00, pending_q} + {3'b000, in_flight};
    assign req_deny  = trig_rise && (doses_q <= committed);
    assign req_over  = trig_rise && !req_deny && (pending_q == 2'(QUEUE_MAX));
    assign req_acc   = trig_rise && !req_deny && !req_over;

    // done_q is raised one cycle early so that it is high exactly in the
    // frame_end cycle that closes the dose; it doubles as the completion strobe.
    assign complete = done_q;

    always_comb begin
        pend_eff = {1'b0, pending_q} + {2'b00, req_acc};
        if (refill_rise && refill_count == 4'd0) begin
            pend_eff = 3'd0;
        end

        // The in-flight decrement applies to a refill value loaded in the same cycle.
        dose_base = refill_rise ? refill_count : doses_q;
        dose_next = dose_base;
        if (complete && dose_base != 4'd0) begin
            dose_next = dose_base - 4'd1;
        end

        state_next = state;
        idx_next   = frame_idx;
        launch     = 1'b0;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (pend_eff != 3'd0) begin
                        state_next = S_OPEN;
                        idx_next   = '0;
                        launch     = 1'b1;
                    end
                end
                S_OPEN: begin
                    if (frame_idx == IW'(OPEN_FRAMES - 1)) begin
                        state_next = S_CLOSE;
                        idx_next   = '0;
                    end else begin
                        idx_next = frame_idx + IW'(1);
                    end
                end
                S_CLOSE: begin
                    if (frame_idx == IW'(CLOSE_FRAMES - 1)) begin
                        idx_next = '0;
                        if (pend_eff != 3'd0 && dose_next != 4'd0) begin
                            state_next = S_OPEN;
                            launch     = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        idx_next = frame_idx + IW'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                end
            endcase
        end

        pend_next = 2'(pend_eff - {2'b00, launch});

        cnt_next   = frame_end ? '0 : frame_cnt + CW'(1);
        // Width only changes on a frame boundary so each frame carries one whole pulse.
        width_next = width_reg;
        if (frame_end) begin
            width_next = (state_next == S_OPEN) ? CW'(PULSE_OPEN) : CW'(PULSE_CLOSED);
        end

        over_next = (refill_rise ? 1'b0 : overflow_q) | req_over;
        deny_next = (refill_rise ? 1'b0 : denied_q) | req_deny
                    | (complete && dose_base == 4'd0);

        done_next = (state == S_CLOSE) && (frame_cnt == CW'(PWM_PERIOD - 2))
                    && (frame_idx == IW'(CLOSE_FRAMES - 1));
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            frame_cnt  <= '0;
            width_reg  <= CW'(PULSE_CLOSED);
            frame_idx  <= '0;
            trig_q     <= 1'b0;
            refill_q   <= 1'b0;
            pending_q  <= 2'd0;
            doses_q    <= 4'd0;
            overflow_q <= 1'b0;
            denied_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            pwm_q      <= 1'b1;
        end else begin
            state      <= state_next;
            frame_cnt  <= cnt_next;
            width_reg  <= width_next;
            frame_idx  <= idx_next;
            trig_q     <= trigger;
            refill_q   <= refill;
            pending_q  <= pend_next;
            doses_q    <= dose_next;
            overflow_q <= over_next;
            denied_q   <= deny_next;
            done_q     <= done_next;
            busy_q     <= (state_next != S_IDLE);
            pwm_q      <= (cnt_next < width_next);
        end
    end

    assign servo_pwm  = pwm_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign doses_left = doses_q;
    assign empty      = (doses_q == 4'd0);
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign denied     = denied_q;

endmodule

// File: tb/tb_dose_actuator.sv
// tb/tb_dose_actuator.sv - scoreboard bench for dose_actuator with a dose-schedule reference model
module tb_dose_actuator;

    localparam int P  = 100;
    localparam int PC = 5;
    localparam int PO = 10;
    localparam int OF = 2;
    localparam int CF = 1;
    localparam int QM = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic       refill = 1'b0;
    logic [3:0] refill_count = 4'd0;
    logic       servo_pwm, busy, done, empty, overflow, denied;
    logic [3:0] doses_left;
    logic [1:0] pending;

    dose_actuator #(
        .PWM_PERIOD  (P),
        .PULSE_CLOSED(PC),
        .PULSE_OPEN  (PO),
        .OPEN_FRAMES (OF),
        .CLOSE_FRAMES(CF),
        .QUEUE_MAX   (QM)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .trigger     (trigger),
        .refill      (refill),
        .refill_count(refill_count),
        .servo_pwm   (servo_pwm),
        .busy        (busy),
        .done        (done),
        .doses_left  (doses_left),
        .empty       (empty),
        .pending     (pending),
        .overflow    (overflow),
        .denied      (denied)
    );

    always #5 clk = ~clk;

    // cyc equals the DUT frame counter position modulo P after each reset release
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        int c;
        int d;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   last_end = 0;
    int   avail = 0;
    bit   m_den = 1'b0;
    bit   m_ovf = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int pending_at(input int c);
        int n = 0;
        foreach (starts[i]) if (starts[i] > c) n++;
        return n;
    endfunction

    function automatic bit exp_open(input int f);
        foreach (starts[i]) if (starts[i] <= f && f < starts[i] + OF * P) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy(input int f);
        foreach (starts[i]) if (starts[i] <= f && f < starts[i] + (OF + CF) * P) return 1'b1;
        return 1'b0;
    endfunction

    // done monitor: every done pulse must match the next scheduled completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.c);
                    @(negedge clk);
                    check("doses_after_done", int'(doses_left), e.d);
                end
            end
        end
    end

    // frame monitor: pulse width per frame and busy mid-frame
    initial begin
        int hi = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hi = 0;
            end else begin
                if (servo_pwm) hi++;
                if (cyc % P == 50) check("busy_mid_frame", int'(busy), int'(exp_busy(cyc - 50)));
                if (cyc % P == P - 1) begin
                    check("pwm_width", hi, exp_open(cyc - (P - 1)) ? PO : PC);
                    hi = 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_refill(input int n);
        @(posedge clk);
        #1;
        refill_count = 4'(n);
        refill = 1'b1;
        avail = n;
        m_den = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        refill = 1'b0;
        @(negedge clk);
        check("doses_after_refill", int'(doses_left), n);
        check("empty_after_refill", int'(empty), int'(n == 0));
    endtask

    task automatic do_trigger();
        int t, s, d, pnd;
        @(posedge clk);
        #1;
        t = cyc;
        trigger = 1'b1;
        pnd = pending_at(t);
        if (avail == 0) begin
            m_den = 1'b1;
        end else if (pnd >= QM) begin
            m_ovf = 1'b1;
        end else begin
            s = (t / P + 1) * P;
            if (last_end > s) s = last_end;
            d = s + (OF + CF) * P - 1;
            starts.push_back(s);
            last_end = d + 1;
            avail--;
            exp_q.push_back('{c: d, d: avail});
        end
        @(posedge clk);
        #1;
        trigger = 1'b0;
        @(negedge clk);
        check("pending_after_trigger", int'(pending), pending_at(cyc));
    endtask

    task automatic settle();
        int n = 0;
        while ((exp_q.size() != 0 || cyc <= last_end + P) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL settle_timeout: %0d completions outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("settle_doses_left", int'(doses_left), avail);
        check("settle_empty", int'(empty), int'(avail == 0));
        check("settle_busy", int'(busy), 0);
        check("settle_pending", int'(pending), 0);
        check("settle_denied", int'(denied), int'(m_den));
        check("settle_overflow", int'(overflow), int'(m_ovf));
        starts.delete();
    endtask

    initial begin
        int n, g;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_doses", int'(doses_left), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_denied", int'(denied), 0);
        check("reset_pwm", int'(servo_pwm), 1);
        check("reset_done", int'(done), 0);

        // single dose, trigger at cycle 30
        do_refill(3);
        wait_cyc(29);
        do_trigger();
        settle();

        // three triggers close together
        do_refill(3);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(posedge clk);
            do_trigger();
        end
        settle();

        // second request finds the compartment committed
        do_refill(1);
        do_trigger();
        repeat (5) @(posedge clk);
        do_trigger();
        settle();

        // queue saturation
        do_refill(15);
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(posedge clk);
            do_trigger();
        end
        settle();

        // randomized scenarios
        for (int k = 0; k < 12; k++) begin
            do_refill(int'($urandom_range(0, 15)));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                g = int'($urandom_range(1, 250));
                repeat (g) @(posedge clk);
                do_trigger();
            end
            settle();
        end

        // reset in the middle of an open frame
        do_refill(3);
        do_trigger();
        wait_cyc(starts[0] + 50);
        reset = 1'b1;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_doses", int'(doses_left), 0);
        check("midreset_pending", int'(pending), 0);
        check("midreset_empty", int'(empty), 1);
        check("midreset_done", int'(done), 0);
        exp_q.delete();
        starts.delete();
        last_end = 0;
        avail = 0;
        m_den = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cyc(3 * P + 10);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
